// File: rtl/trx_scheduler.sv
// Time-shares the RF front end between RX listening windows and TX bursts.
// TX bytes are queued in a small FIFO; guard gaps separate every turnaround.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | parked (config mode or after reset), rx_mode=0
// LISTEN   | RX path active, listen window timer running
// TURN_TX  | guard gap before transmitting
// TX_LOAD  | pop FIFO head into TX_Buffer (1 cycle)
// TX_SHIFT | shifting the loaded byte out, one bit per sh_en
// TURN_RX  | guard gap before returning to RX
module trx_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_CYC  = 8,
  parameter int MAX_BURST  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_CONFIG,
  input  logic                          tx_req,
  input  logic [7:0]                    tx_byte,
  input  logic                          pkt_rec,
  input  logic                          sh_en,
  input  logic [15:0]                   listen_len,
  input  logic                          ovf_clr,
  output logic                          rx_mode,
  output logic                          tx_ld,
  output logic [7:0]                    tx_data,
  output logic                          tx_en,
  output logic                          pkt_evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYC);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LISTEN   = 3'd1;
  localparam logic [2:0] S_TURN_TX  = 3'd2;
  localparam logic [2:0] S_TX_LOAD  = 3'd3;
  localparam logic [2:0] S_TX_SHIFT = 3'd4;
  localparam logic [2:0] S_TURN_RX  = 3'd5;

  logic [2:0]    state_q,   state_d;
  logic [15:0]   lcnt_q,    lcnt_d;
  logic [GW-1:0] gcnt_q,    gcnt_d;
  logic [2:0]    bitcnt_q,  bitcnt_d;
  logic [BW-1:0] burst_q,   burst_d;
  logic          rx_mode_q, rx_mode_d;
  logic          tx_ld_q,   tx_ld_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q,   tx_en_d;
  logic          pkt_evt_q, pkt_evt_d;
  logic          pkt_rec_q, pkt_rec_d;
  logic          ovf_q,     ovf_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic          pkt_edge;
  logic          pop;
  logic          push;
  logic [15:0]   lreload;

  assign pkt_edge = pkt_rec && !pkt_rec_q;
  assign lreload  = (listen_len == 16'd0) ? 16'd1 : listen_len;

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    gcnt_d    = gcnt_q;
    bitcnt_d  = bitcnt_q;
    burst_d   = burst_q;
    rx_mode_d = rx_mode_q;
    tx_data_d = tx_data_q;
    tx_ld_d   = 1'b0;
    tx_en_d   = 1'b0;
    pkt_evt_d = 1'b0;
    pkt_rec_d = pkt_rec;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        rx_mode_d = 1'b0;
        if (!i_CONFIG) begin
          state_d   = S_LISTEN;
          rx_mode_d = 1'b1;
          lcnt_d    = lreload;
        end
      end
      S_LISTEN: begin
        pkt_evt_d = pkt_edge;
        if (i_CONFIG) begin
          state_d   = S_IDLE;
          rx_mode_d = 1'b0;
          lcnt_d    = 16'd0;
        end else if (pkt_edge) begin
          lcnt_d = lreload;
        end else if (lcnt_q <= 16'd1) begin
          if (cnt_q != '0) begin
            state_d   = S_TURN_TX;
            rx_mode_d = 1'b0;
            gcnt_d    = GUARD_INIT;
            lcnt_d    = 16'd0;
          end else begin
            lcnt_d = lreload;
          end
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      S_TURN_TX: begin
        if (i_CONFIG) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end else if (gcnt_q <= 1) begin
          state_d = S_TX_LOAD;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      S_TX_LOAD: begin
        pop       = (cnt_q != '0);
        tx_ld_d   = 1'b1;
        tx_data_d = mem_q[rd_ptr_q];
        bitcnt_d  = 3'd0;
        burst_d   = burst_q + 1'b1;
        state_d   = S_TX_SHIFT;
      end
      S_TX_SHIFT: begin
        tx_en_d = sh_en;
        if (sh_en) begin
          bitcnt_d = bitcnt_q + 1'b1;
          // Byte boundary: config requests are only honoured here.
          if (bitcnt_q == 3'd7) begin
            if (!i_CONFIG && (cnt_q != '0) && (burst_q < BURST_MAX)) begin
              state_d = S_TX_LOAD;
            end else if (i_CONFIG) begin
              state_d = S_IDLE;
              burst_d = '0;
            end else begin
              state_d = S_TURN_RX;
              gcnt_d  = GUARD_INIT;
              burst_d = '0;
            end
          end
        end
      end
      S_TURN_RX: begin
        if (i_CONFIG) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end else if (gcnt_q <= 1) begin
          state_d   = S_LISTEN;
          rx_mode_d = 1'b1;
          lcnt_d    = lreload;
          gcnt_d    = '0;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        rx_mode_d = 1'b0;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    push     = tx_req && ((cnt_q != CNT_FULL) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (tx_req && !push) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      lcnt_q    <= '0;
      gcnt_q    <= '0;
      bitcnt_q  <= '0;
      burst_q   <= '0;
      rx_mode_q <= 1'b0;
      tx_ld_q   <= 1'b0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      pkt_evt_q <= 1'b0;
      pkt_rec_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      gcnt_q    <= gcnt_d;
      bitcnt_q  <= bitcnt_d;
      burst_q   <= burst_d;
      rx_mode_q <= rx_mode_d;
      tx_ld_q   <= tx_ld_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      pkt_evt_q <= pkt_evt_d;
      pkt_rec_q <= pkt_rec_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rx_mode  = rx_mode_q;
  assign tx_ld    = tx_ld_q;
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign pkt_evt  = pkt_evt_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_trx_scheduler.sv
// Bench for trx_scheduler: FIFO vector table, directed turnaround sequences,
// and a random run checked against a queue-based reference model.
module tb_trx_scheduler;

  logic        clk = 1'b0;
  logic        rst, i_CONFIG, tx_req, pkt_rec, sh_en, ovf_clr;
  logic [7:0]  tx_byte;
  logic [15:0] listen_len;
  logic        rx_mode, tx_ld, tx_en, pkt_evt, ovf;
  logic [7:0]  tx_data;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int failures = 0;
  bit sh_auto = 1'b0;
  int sh_div = 0;

  always #5 clk = ~clk;

  trx_scheduler dut (
    .clk(clk), .rst(rst), .i_CONFIG(i_CONFIG), .tx_req(tx_req), .tx_byte(tx_byte),
    .pkt_rec(pkt_rec), .sh_en(sh_en), .listen_len(listen_len), .ovf_clr(ovf_clr),
    .rx_mode(rx_mode), .tx_ld(tx_ld), .tx_data(tx_data), .tx_en(tx_en),
    .pkt_evt(pkt_evt), .fifo_cnt(fifo_cnt), .ovf(ovf)
  );

  typedef struct {
    logic       req;
    logic [7:0] b;
    logic       clr;
    int         cnt;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (sh_auto) begin
      sh_div = (sh_div + 1) % 4;
      sh_en  = (sh_div == 0);
    end
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0:       return rx_mode === 1'b1;
      1:       return rx_mode === 1'b0;
      2:       return tx_ld === 1'b1;
      default: return tx_en === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int budget, input string name, output int n);
    for (n = 1; n <= budget; n++) begin
      step();
      if (cond(kind)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout after %0d cycles", name, budget);
  endtask

  task automatic do_reset();
    rst = 1'b0; i_CONFIG = 1'b1; tx_req = 1'b0; tx_byte = 8'h00;
    pkt_rec = 1'b0; ovf_clr = 1'b0; sh_en = 1'b0;
    step();
    step();
    chk("rst_rx_mode", rx_mode, 0);
    chk("rst_tx_ld", tx_ld, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_pkt_evt", pkt_evt, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
  endtask

  initial begin
    vec_t tbl[8];
    int n, n2, bad, evts, en_after;
    logic [7:0] got[$];
    int gwin[$];
    int win;
    logic rx_prev;

    listen_len = 16'd20;
    do_reset();

    // FIFO fill / overflow / ovf_clr priority while parked in config mode
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 2, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 3, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 4, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 4, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 4, 1'b0};
    tbl[6] = '{1'b1, 8'h06, 1'b1, 4, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 4, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tx_req = tbl[i].req; tx_byte = tbl[i].b; ovf_clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_cnt", i), fifo_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("tbl%0d_rx", i), rx_mode, 0);
    end
    tx_req = 1'b0; ovf_clr = 1'b0;

    // Burst limit: 01..03 in the first TX window, 04 in the second
    sh_auto = 1'b1;
    i_CONFIG = 1'b0;
    win = 0; rx_prev = rx_mode;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (rx_prev && !rx_mode) win++;
      if (tx_ld) begin got.push_back(tx_data); gwin.push_back(win); end
      rx_prev = rx_mode;
      if (got.size() == 4 && rx_mode) break;
    end
    chk("burst_nbytes", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("burst_data%0d", i), got[i], i + 1);
        chk($sformatf("burst_win%0d", i), gwin[i], (i < 3) ? 1 : 2);
      end
    end
    chk("burst_cnt_after", fifo_cnt, 0);
    chk("burst_ovf_kept", ovf, 1);

    // T1: idle listening never transmits
    do_reset();
    i_CONFIG = 1'b0;
    step();
    chk("t1_rx_enter", rx_mode, 1);
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (!rx_mode || tx_ld || tx_en) bad++;
    end
    chk("t1_listen_only", bad, 0);

    // T2: single byte, turnaround timing
    do_reset();
    i_CONFIG = 1'b0;
    wait_for(0, 5, "t2_rx_rise", n);
    chk("t2_rx_rise_lat", n, 1);
    tx_req = 1'b1; tx_byte = 8'hA5;
    step();
    tx_req = 1'b0;
    wait_for(1, 100, "t2_rx_fall", n2);
    chk("t2_window_len", n2 + 1, 20);
    wait_for(2, 50, "t2_ld", n);
    chk("t2_ld_latency", n, 9);
    chk("t2_tx_data", tx_data, 8'hA5);
    chk("t2_rx_during_ld", rx_mode, 0);
    for (int k = 0; k < 8; k++) wait_for(3, 20, "t2_en", n);
    wait_for(0, 50, "t2_rx_back", n);
    chk("t2_guard_rx", n, 8);
    chk("t2_cnt", fifo_cnt, 0);

    // T4: periodic packets keep the window open despite a queued byte
    do_reset();
    i_CONFIG = 1'b0; tx_req = 1'b1; tx_byte = 8'h3C;
    wait_for(0, 5, "t4_rx_rise", n);
    tx_req = 1'b0;
    evts = 0; bad = 0;
    for (int p = 0; p < 12; p++) begin
      pkt_rec = 1'b1;
      step();
      if (pkt_evt) evts++;
      if (!rx_mode) bad++;
      pkt_rec = 1'b0;
      for (int c = 0; c < 14; c++) begin
        step();
        if (pkt_evt) evts++;
        if (!rx_mode) bad++;
      end
    end
    chk("t4_pkt_evts", evts, 12);
    chk("t4_never_left", bad, 0);
    chk("t4_cnt", fifo_cnt, 1);

    // T5: config request mid-byte finishes the byte then parks
    sh_auto = 1'b0;
    do_reset();
    tx_req = 1'b1; tx_byte = 8'h11; step();
    tx_byte = 8'h22; step();
    tx_req = 1'b0;
    listen_len = 16'd5; i_CONFIG = 1'b0;
    wait_for(2, 100, "t5_ld", n);
    chk("t5_data", tx_data, 8'h11);
    n2 = 0; en_after = 0;
    for (int k = 1; k <= 8; k++) begin
      sh_en = 1'b1;
      if (k == 4) i_CONFIG = 1'b1;
      step();
      sh_en = 1'b0;
      if (tx_en) begin n2++; if (k > 4) en_after++; end
      step(); step();
    end
    chk("t5_total_en", n2, 8);
    chk("t5_en_after_cfg", en_after, 4);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      sh_en = (c % 3 == 0);
      step();
      if (tx_en || tx_ld || rx_mode) bad++;
    end
    sh_en = 1'b0;
    chk("t5_parked", bad, 0);
    chk("t5_cnt_kept", fifo_cnt, 1);

    // T6: reset pulse in the middle of TX_SHIFT
    sh_auto = 1'b1;
    do_reset();
    i_CONFIG = 1'b0; tx_req = 1'b1; tx_byte = 8'h5A;
    step();
    tx_req = 1'b1; tx_byte = 8'h6B;
    step();
    tx_req = 1'b0;
    wait_for(2, 100, "t6_ld", n);
    wait_for(3, 20, "t6_en", n);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_rx_mode", rx_mode, 0);
    chk("t6_tx_ld", tx_ld, 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_tx_en", tx_en, 0);
    chk("t6_cnt", fifo_cnt, 0);
    chk("t6_ovf", ovf, 0);
    wait_for(0, 5, "t6_rx_rise", n);
    chk("t6_idle_to_listen", n, 1);

    // Random run against a queue-based reference model
    begin
      logic [7:0] q[$];
      logic m_ovf, pkt_prev, r_req, r_clr, r_pkt, acc;
      logic [7:0] r_byte;
      int en_cnt, win_ld;
      bit seen_ld;
      sh_auto = 1'b0;
      listen_len = 16'd4;
      do_reset();
      i_CONFIG = 1'b0;
      m_ovf = 1'b0; pkt_prev = 1'b0; rx_prev = 1'b0;
      en_cnt = 0; win_ld = 0; seen_ld = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        tx_req  = ($urandom_range(0, 5) == 0);
        tx_byte = 8'($urandom);
        ovf_clr = ($urandom_range(0, 19) == 0);
        sh_en   = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0) pkt_rec = ~pkt_rec;
        if ($urandom_range(0, 199) == 0) i_CONFIG = ~i_CONFIG;
        if ($urandom_range(0, 99) == 0) listen_len = 16'($urandom_range(0, 12));
        r_req = tx_req; r_byte = tx_byte; r_clr = ovf_clr; r_pkt = pkt_rec;
        step();
        acc = r_req && ((q.size() < 4) || tx_ld);
        if (r_req && !acc) m_ovf = 1'b1;
        else if (r_clr) m_ovf = 1'b0;
        if (tx_ld) begin
          if (q.size() == 0) chk("rnd_pop_empty", 1, 0);
          else begin chk("rnd_tx_data", tx_data, q[0]); void'(q.pop_front()); end
          if (seen_ld) chk("rnd_bits_per_byte", en_cnt, 8);
          seen_ld = 1'b1; en_cnt = 0; win_ld++;
        end
        if (acc) q.push_back(r_byte);
        if (tx_en) en_cnt++;
        chk("rnd_fifo_cnt", fifo_cnt, q.size());
        chk("rnd_ovf", ovf, m_ovf);
        chk("rnd_pkt_evt", pkt_evt, r_pkt && !pkt_prev && rx_prev);
        chk("rnd_ld_rx", tx_ld && rx_mode, 0);
        chk("rnd_en_rx", tx_en && rx_mode, 0);
        chk("rnd_ld_en", tx_ld && tx_en, 0);
        if (rx_mode && !rx_prev) begin
          chk("rnd_burst_max", win_ld <= 3, 1);
          win_ld = 0;
        end
        pkt_prev = r_pkt;
        rx_prev = rx_mode;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
